// File: rtl/seg_display_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : seg_display_arbiter
//  Description : Round-robin arbiter sharing one 7-segment digit between two
//                requesters, with minimum hold time, blanking gap between
//                owners and active-low hex-to-segment decode.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg_display_arbiter #(
    parameter int HOLD_CYCLES = 12_500_000,
    parameter int GAP_CYCLES  = 250_000
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_Req_0,
    input  logic [3:0] i_Data_0,
    input  logic       i_Req_1,
    input  logic [3:0] i_Data_1,
    output logic       o_Grant_0,
    output logic       o_Grant_1,
    output logic [6:0] o_Segments
);

    localparam int MAX_CYCLES = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES < 1) ? 1 : $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] c_HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_GAP_LAST  = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;
    localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);
    localparam logic [6:0]       c_BLANK     = 7'h7F;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t           r_state,    w_state;
    logic             r_owner,    w_owner;
    logic             r_rr,       w_rr;
    logic [CNT_W-1:0] r_count,    w_count;
    logic             r_grant_0,  w_grant_0;
    logic             r_grant_1,  w_grant_1;
    logic [6:0]       r_segments, w_segments;

    logic             w_pick;
    logic             w_owner_req;
    logic             w_other_req;
    logic [3:0]       w_owner_data;

    // Active-low {G,F,E,D,C,B,A}
    function automatic logic [6:0] hex_to_seg(input logic [3:0] value);
        logic [6:0] seg;
        case (value)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    // Contention goes to the round-robin favourite, otherwise to whoever asks
    assign w_pick       = (i_Req_0 & i_Req_1) ? r_rr : i_Req_1;
    assign w_owner_req  = r_owner ? i_Req_1  : i_Req_0;
    assign w_other_req  = r_owner ? i_Req_0  : i_Req_1;
    assign w_owner_data = r_owner ? i_Data_1 : i_Data_0;

    always_comb begin
        w_state    = r_state;
        w_owner    = r_owner;
        w_rr       = r_rr;
        w_count    = r_count;
        w_grant_0  = r_grant_0;
        w_grant_1  = r_grant_1;
        w_segments = r_segments;

        case (r_state)
            ST_IDLE: begin
                w_segments = c_BLANK;
                w_grant_0  = 1'b0;
                w_grant_1  = 1'b0;
                if (i_Req_0 | i_Req_1) begin
                    w_owner   = w_pick;
                    w_grant_0 = ~w_pick;
                    w_grant_1 = w_pick;
                    w_count   = '0;
                    w_state   = ST_GRANT;
                end
            end

            ST_GRANT: begin
                if (!w_owner_req || ((r_count == c_HOLD_LAST) && w_other_req)) begin
                    w_grant_0  = 1'b0;
                    w_grant_1  = 1'b0;
                    w_segments = c_BLANK;
                    w_count    = '0;
                    w_rr       = ~r_owner;
                    w_state    = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
                end else begin
                    w_segments = hex_to_seg(w_owner_data);
                    if (r_count != c_HOLD_LAST) begin
                        w_count = r_count + c_CNT_ONE;
                    end
                end
            end

            ST_GAP: begin
                w_grant_0  = 1'b0;
                w_grant_1  = 1'b0;
                w_segments = c_BLANK;
                if (r_count >= c_GAP_LAST) begin
                    w_count = '0;
                    w_state = ST_IDLE;
                end else begin
                    w_count = r_count + c_CNT_ONE;
                end
            end

            default: begin
                w_state    = ST_IDLE;
                w_grant_0  = 1'b0;
                w_grant_1  = 1'b0;
                w_segments = c_BLANK;
                w_count    = '0;
            end
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_state    <= ST_IDLE;
            r_owner    <= 1'b0;
            r_rr       <= 1'b0;
            r_count    <= '0;
            r_grant_0  <= 1'b0;
            r_grant_1  <= 1'b0;
            r_segments <= c_BLANK;
        end else begin
            r_state    <= w_state;
            r_owner    <= w_owner;
            r_rr       <= w_rr;
            r_count    <= w_count;
            r_grant_0  <= w_grant_0;
            r_grant_1  <= w_grant_1;
            r_segments <= w_segments;
        end
    end

    assign o_Grant_0  = r_grant_0;
    assign o_Grant_1  = r_grant_1;
    assign o_Segments = r_segments;

endmodule
`default_nettype wire
